baud_frame_timer: RTL and testbench

- Parametrised successor to the fixed-rate baud counter used by the IrDA receive path.
- Generates per-bit timing for a whole character frame: a programmable mid-bit sample strobe, an end-of-bit strobe, an IrDA pulse-width window, a bit index and a frame-done strobe.
- Runtime-configurable divisor, sample point, pulse length and frame length; one-shot or continuous operation; resynchronisable by the start-bit detector.
- Sits between the RX start-edge detector and the bit-shift/deframer logic; the TX side reuses it for pulse shaping.

---
 rtl/baud_frame_timer.sv | 110 +++++++++++
 tb/tb_baud_frame_timer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/baud_frame_timer.sv
// rtl/baud_frame_timer.sv - per-bit and per-frame baud timing with IrDA pulse window
module baud_frame_timer #(
    parameter int CNT_W          = 12,
    parameter int BIT_W          = 4,
    parameter int DIV_DEFAULT    = 1302,
    parameter int SAMPLE_DEFAULT = 651,
    parameter int PULSE_DEFAULT  = 244,
    parameter int FRAME_DEFAULT  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             restart,
    input  logic             cont,
    input  logic [CNT_W-1:0] divisor,
    input  logic [CNT_W-1:0] sample_pt,
    input  logic [CNT_W-1:0] pulse_len,
    input  logic [BIT_W-1:0] frame_bits,
    output logic             sample_tick,
    output logic             bit_tick,
    output logic             pulse_active,
    output logic [BIT_W-1:0] bit_index,
    output logic             frame_done,
    output logic             busy,
    output logic             cfg_err
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DIV_DEFAULT);
    localparam logic [CNT_W-1:0] SAMP_INIT = CNT_W'(SAMPLE_DEFAULT);
    localparam logic [CNT_W-1:0] PLS_INIT = CNT_W'(PULSE_DEFAULT);
    localparam logic [BIT_W-1:0] FB_INIT = BIT_W'(FRAME_DEFAULT);

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [BIT_W-1:0] bit_q;
    logic [CNT_W-1:0] div_q;
    logic [CNT_W-1:0] samp_q;
    logic [CNT_W-1:0] pls_q;
    logic [BIT_W-1:0] fb_q;
    logic             err_q;

    logic run;
    logic cfg_ok;
    logic last_cnt;
    logic last_bit;

    assign run      = (state == RUN);
    assign cfg_ok   = (divisor >= CNT_W'(2)) && (sample_pt < divisor) && (frame_bits != '0);
    assign last_cnt = (count == div_q - CNT_W'(1));
    assign last_bit = (bit_q == fb_q - BIT_W'(1));

    // Decodes qualify on RUN so every strobe is quiet in IDLE regardless of count.
    assign sample_tick  = run && (count == samp_q);
    assign bit_tick     = run && last_cnt;
    assign pulse_active = run && (count < pls_q);
    assign frame_done   = run && last_cnt && last_bit;
    assign bit_index    = bit_q;
    assign busy         = run;
    assign cfg_err      = err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            count  <= '0;
            bit_q  <= '0;
            div_q  <= DIV_INIT;
            samp_q <= SAMP_INIT;
            pls_q  <= PLS_INIT;
            fb_q   <= FB_INIT;
            err_q  <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (!enable) begin
                state <= IDLE;
                count <= '0;
                bit_q <= '0;
            end else if (restart) begin
                count <= '0;
                bit_q <= '0;
                if (cfg_ok) begin
                    state  <= RUN;
                    div_q  <= divisor;
                    samp_q <= sample_pt;
                    pls_q  <= pulse_len;
                    fb_q   <= frame_bits;
                end else begin
                    state <= IDLE;
                    err_q <= 1'b1;
                end
            end else if (run) begin
                if (last_cnt) begin
                    count <= '0;
                    if (last_bit) begin
                        bit_q <= '0;
                        if (!cont) begin
                            state <= IDLE;
                        end
                    end else begin
                        bit_q <= bit_q + BIT_W'(1);
                    end
                end else begin
                    count <= count + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_baud_frame_timer.sv
// tb/tb_baud_frame_timer.sv - randomized and directed check of baud_frame_timer against a frame-level model
module tb_baud_frame_timer;

    localparam int DIV_D  = 1302;
    localparam int SAMP_D = 651;
    localparam int PLS_D  = 244;
    localparam int FB_D   = 10;

    logic        clk = 1'b0;
    logic        reset, enable, restart, cont;
    logic [11:0] divisor, sample_pt, pulse_len;
    logic [3:0]  frame_bits;
    logic        sample_tick, bit_tick, pulse_active, frame_done, busy, cfg_err;
    logic [3:0]  bit_index;

    always #5 clk = ~clk;

    baud_frame_timer dut (
        .clk(clk), .reset(reset), .enable(enable), .restart(restart), .cont(cont),
        .divisor(divisor), .sample_pt(sample_pt), .pulse_len(pulse_len), .frame_bits(frame_bits),
        .sample_tick(sample_tick), .bit_tick(bit_tick), .pulse_active(pulse_active),
        .bit_index(bit_index), .frame_done(frame_done), .busy(busy), .cfg_err(cfg_err)
    );

    int n_vec = 0;
    int n_err = 0;

    // Model: elapsed clocks since the accepted start; count and bit derive by division.
    bit     m_run = 1'b0;
    bit     m_err = 1'b0;
    longint m_e = 0;
    int     m_div = DIV_D, m_samp = SAMP_D, m_pls = PLS_D, m_fb = FB_D;

    int cyc = 0, c0 = 0;
    int n_bt, n_fd, n_pa, fd_cyc, st_cyc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    task automatic clear_stats();
        n_bt = 0; n_fd = 0; n_pa = 0; fd_cyc = -1; st_cyc = -1;
    endtask

    task automatic set_cfg(input int dv, input int sp, input int pl, input int fb);
        divisor = 12'(dv); sample_pt = 12'(sp); pulse_len = 12'(pl); frame_bits = 4'(fb);
    endtask

    task automatic model_edge();
        if (reset) begin
            m_run = 0; m_e = 0; m_err = 0;
            m_div = DIV_D; m_samp = SAMP_D; m_pls = PLS_D; m_fb = FB_D;
        end else begin
            m_err = 0;
            if (!enable) begin
                m_run = 0; m_e = 0;
            end else if (restart) begin
                m_e = 0;
                if (divisor < 2 || sample_pt >= divisor || frame_bits == 0) begin
                    m_err = 1; m_run = 0;
                end else begin
                    m_div = int'(divisor); m_samp = int'(sample_pt);
                    m_pls = int'(pulse_len); m_fb = int'(frame_bits); m_run = 1;
                end
            end else if (m_run) begin
                m_e++;
                if (m_e == longint'(m_div) * m_fb) begin
                    m_e = 0;
                    if (!cont) m_run = 0;
                end
            end
        end
    endtask

    task automatic step();
        int cnt, bi;
        @(posedge clk);
        model_edge();
        cyc++;
        @(negedge clk);
        cnt = m_run ? int'(m_e % m_div) : -1;
        bi  = m_run ? int'(m_e / m_div) : 0;
        check("busy", 32'(busy), 32'(m_run));
        check("cfg_err", 32'(cfg_err), 32'(m_err));
        check("sample_tick", 32'(sample_tick), 32'(m_run && cnt == m_samp));
        check("bit_tick", 32'(bit_tick), 32'(m_run && cnt == m_div - 1));
        check("pulse_active", 32'(pulse_active), 32'(m_run && cnt < m_pls));
        check("bit_index", 32'(bit_index), 32'(bi));
        check("frame_done", 32'(frame_done), 32'(m_run && cnt == m_div - 1 && bi == m_fb - 1));
        if (bit_tick) n_bt++;
        if (frame_done) begin n_fd++; fd_cyc = cyc; end
        if (pulse_active) n_pa++;
        if (sample_tick && st_cyc < 0) st_cyc = cyc;
    endtask

    task automatic run_n(input int n);
        repeat (n) step();
    endtask

    initial begin
        reset = 1; enable = 0; restart = 0; cont = 0;
        set_cfg(DIV_D, SAMP_D, PLS_D, FB_D);
        clear_stats();
        run_n(3);
        reset = 0;
        run_n(2);

        // Default one-shot frame
        enable = 1; restart = 1; clear_stats();
        step(); c0 = cyc; restart = 0;
        run_n(13030);
        check("dflt_first_sample", 32'(st_cyc - c0 + 1), 32'd652);
        check("dflt_frame_done", 32'(fd_cyc - c0 + 1), 32'd13020);
        check("dflt_bit_ticks", 32'(n_bt), 32'd10);
        check("dflt_pulse_cycles", 32'(n_pa), 32'(10 * PLS_D));

        // Continuous short frames
        cont = 1; set_cfg(4, 2, 1, 3); restart = 1; clear_stats();
        step(); restart = 0;
        run_n(48);
        check("cont_frames", 32'(n_fd), 32'd4);
        check("cont_bit_ticks", 32'(n_bt), 32'd12);
        enable = 0; step(); enable = 1; cont = 0;

        // Rejected starts
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: set_cfg(1, 0, 0, 10);
                1: set_cfg(100, 100, 10, 10);
                default: set_cfg(100, 50, 10, 0);
            endcase
            restart = 1; step(); restart = 0; run_n(3);
        end

        // Config change mid-frame ignored until restart
        set_cfg(DIV_D, SAMP_D, PLS_D, FB_D); restart = 1;
        step(); restart = 0;
        run_n(3 * DIV_D);
        set_cfg(8, 3, 2, FB_D);
        run_n(5 * DIV_D + 500 - 3 * DIV_D);
        restart = 1; step(); restart = 0;
        run_n(40);
        enable = 0; step(); enable = 1;

        // enable drop with restart high, then reset mid-frame
        set_cfg(DIV_D, SAMP_D, PLS_D, FB_D); clear_stats();
        restart = 1; step(); restart = 0; run_n(2000);
        enable = 0; restart = 1; step(); restart = 0; enable = 1; run_n(2);
        restart = 1; step(); restart = 0; run_n(1500);
        reset = 1; step(); reset = 0; run_n(3);
        check("abort_no_frame_done", 32'(n_fd), 32'd0);

        // Pulse window extremes
        set_cfg(DIV_D, SAMP_D, 0, FB_D); restart = 1; clear_stats();
        step(); restart = 0; run_n(DIV_D - 1);
        check("pulse0_cycles", 32'(n_pa), 32'd0);
        set_cfg(DIV_D, SAMP_D, 2000, FB_D); restart = 1; clear_stats();
        step(); restart = 0; run_n(DIV_D - 1);
        check("pulse2000_cycles", 32'(n_pa), 32'(DIV_D));
        enable = 0; step(); enable = 1;

        // Randomized traffic, config inputs churn every cycle
        for (int i = 0; i < 6000; i++) begin
            int dv;
            reset   = ($urandom % 500) == 0;
            enable  = ($urandom % 200) != 0;
            restart = ($urandom % 60) == 0;
            if (($urandom % 50) == 0) cont = ~cont;
            dv = int'($urandom_range(1, 20));
            set_cfg(dv, int'($urandom_range(0, dv + 1)), int'($urandom_range(0, dv + 2)),
                    int'($urandom_range(0, 5)));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
